// File: rtl/maria_bus_arbiter_pkg.sv
// Shared types and defaults for the MARIA / 6502 bus arbiter.
// Holds the arbiter state encoding, the counter width and the
// default CPU-cycle latencies used by the top level.
package maria_bus_arbiter_pkg;

    // Bus ownership phases; the encoding is exported on arb_state.
    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_HALT_WAIT = 2'd1,
        ARB_DMA       = 2'd2,
        ARB_RELEASE   = 2'd3
    } arb_state_t;

    localparam int unsigned ARB_CNT_W            = 3;
    localparam int unsigned HALT_LATENCY_DEFAULT = 2;
    localparam int unsigned RELEASE_GAP_DEFAULT  = 1;

    // Convert a cycle-count parameter into a counter load value.
    // Out-of-range values are pinned to 1..7 so the counter can never be
    // loaded with zero (which would stall a counting state) or overflow.
    function automatic logic [ARB_CNT_W-1:0] arb_cycles(input int unsigned cycles);
        logic [ARB_CNT_W-1:0] value;
        if (cycles < 32'd1) begin
            value = 3'd1;
        end else if (cycles > 32'd7) begin
            value = 3'd7;
        end else begin
            value = cycles[ARB_CNT_W-1:0];
        end
        return value;
    endfunction

endpackage

// File: rtl/maria_bus_arbiter_cpu_cycle_counter.sv
// Down-counter of CPU bus cycles used by the arbiter while it waits
// between halting the CPU and granting the bus, and between returning
// the bus and releasing the CPU. Loads take priority over decrements
// and the count saturates at zero instead of wrapping.
module cpu_cycle_counter
    import maria_bus_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [ARB_CNT_W-1:0] load_value,
    input  logic                 dec,
    output logic                 zero,
    output logic                 at_one
);

    logic [ARB_CNT_W-1:0] count_r;

    // Count register: load, decrement on a CPU-cycle strobe, never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 3'd0;
        end else if (load) begin
            count_r <= load_value;
        end else if (dec && (count_r != 3'd0)) begin
            count_r <= count_r - 3'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero   = (count_r == 3'd0);
    assign at_one = (count_r == 3'd1);

endmodule

// File: rtl/maria_bus_arbiter.sv
// MARIA / 6502 system bus arbiter.
// Halts the CPU on a bus-cycle boundary, waits a fixed number of CPU
// cycles, grants MARIA the address bus for its DMA burst, then hands the
// bus back and releases the CPU after a second fixed gap. A separate
// WSYNC latch holds CPU RDY low from a WSYNC write until the next line.
module maria_bus_arbiter
    import maria_bus_arbiter_pkg::*;
#(
    parameter int unsigned HALT_LATENCY = HALT_LATENCY_DEFAULT,
    parameter int unsigned RELEASE_GAP  = RELEASE_GAP_DEFAULT
) (
    input  logic       sysclock,
    input  logic       reset,
    input  logic       cpu_cycle_end,
    input  logic       dma_req,
    input  logic       dma_done,
    input  logic       deassert_ready,
    input  logic       line_start,
    output logic       halt_b,
    output logic       ready,
    output logic       drive_AB,
    output logic [1:0] arb_state
);

    localparam logic [ARB_CNT_W-1:0] HALT_LOAD    = arb_cycles(HALT_LATENCY);
    localparam logic [ARB_CNT_W-1:0] RELEASE_LOAD = arb_cycles(RELEASE_GAP);

    arb_state_t           state_r;
    arb_state_t           state_next_s;
    logic                 halt_b_r;
    logic                 halt_b_next_s;
    logic                 drive_ab_r;
    logic                 drive_ab_next_s;
    logic                 wsync_hold_r;
    logic                 wsync_hold_next_s;
    logic                 ready_r;
    logic                 cnt_load_s;
    logic [ARB_CNT_W-1:0] cnt_load_value_s;
    logic                 cnt_dec_s;
    logic                 cnt_zero_s;
    logic                 cnt_at_one_s;

    cpu_cycle_counter u_cpu_cycle_counter (
        .clk        (sysclock),
        .rst        (reset),
        .load       (cnt_load_s),
        .load_value (cnt_load_value_s),
        .dec        (cnt_dec_s),
        .zero       (cnt_zero_s),
        .at_one     (cnt_at_one_s)
    );

    // Next-state and next-output logic for the bus ownership sequence.
    // The final strobe of a wait both empties the counter and moves the
    // state, so the output edge lands one clock after that strobe.
    always_comb begin
        state_next_s     = state_r;
        halt_b_next_s    = halt_b_r;
        drive_ab_next_s  = drive_ab_r;
        cnt_load_s       = 1'b0;
        cnt_load_value_s = 3'd0;
        cnt_dec_s        = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                drive_ab_next_s = 1'b0;
                if (cpu_cycle_end && dma_req) begin
                    state_next_s     = ARB_HALT_WAIT;
                    halt_b_next_s    = 1'b0;
                    cnt_load_s       = 1'b1;
                    cnt_load_value_s = HALT_LOAD;
                end else begin
                    halt_b_next_s    = 1'b1;
                end
            end
            ARB_HALT_WAIT: begin
                halt_b_next_s = 1'b0;
                // A withdrawn request aborts before the bus is ever granted.
                if (!dma_req) begin
                    state_next_s     = ARB_RELEASE;
                    drive_ab_next_s  = 1'b0;
                    cnt_load_s       = 1'b1;
                    cnt_load_value_s = RELEASE_LOAD;
                end else if (cpu_cycle_end) begin
                    cnt_dec_s = 1'b1;
                    if (cnt_at_one_s || cnt_zero_s) begin
                        state_next_s    = ARB_DMA;
                        drive_ab_next_s = 1'b1;
                    end else begin
                        drive_ab_next_s = 1'b0;
                    end
                end else begin
                    drive_ab_next_s = 1'b0;
                end
            end
            ARB_DMA: begin
                halt_b_next_s = 1'b0;
                if (dma_done) begin
                    state_next_s     = ARB_RELEASE;
                    drive_ab_next_s  = 1'b0;
                    cnt_load_s       = 1'b1;
                    cnt_load_value_s = RELEASE_LOAD;
                end else begin
                    drive_ab_next_s  = 1'b1;
                end
            end
            ARB_RELEASE: begin
                drive_ab_next_s = 1'b0;
                if (cpu_cycle_end) begin
                    cnt_dec_s = 1'b1;
                    if (cnt_at_one_s || cnt_zero_s) begin
                        state_next_s  = ARB_IDLE;
                        halt_b_next_s = 1'b1;
                    end else begin
                        halt_b_next_s = 1'b0;
                    end
                end else begin
                    halt_b_next_s = 1'b0;
                end
            end
            default: begin
                state_next_s    = ARB_IDLE;
                halt_b_next_s   = 1'b1;
                drive_ab_next_s = 1'b0;
            end
        endcase
    end

    // Arbiter state and bus-control output registers.
    always_ff @(posedge sysclock or posedge reset) begin
        if (reset) begin
            state_r    <= ARB_IDLE;
            halt_b_r   <= 1'b1;
            drive_ab_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            halt_b_r   <= halt_b_next_s;
            drive_ab_r <= drive_ab_next_s;
        end
    end

    // WSYNC hold: a set on the same clock as a line start wins, so the
    // CPU stays held until the line after.
    always_comb begin
        if (deassert_ready) begin
            wsync_hold_next_s = 1'b1;
        end else if (line_start) begin
            wsync_hold_next_s = 1'b0;
        end else begin
            wsync_hold_next_s = wsync_hold_r;
        end
    end

    // WSYNC hold latch and the registered CPU RDY derived from it.
    always_ff @(posedge sysclock or posedge reset) begin
        if (reset) begin
            wsync_hold_r <= 1'b0;
            ready_r      <= 1'b1;
        end else begin
            wsync_hold_r <= wsync_hold_next_s;
            ready_r      <= ~wsync_hold_next_s;
        end
    end

    assign halt_b    = halt_b_r;
    assign drive_AB  = drive_ab_r;
    assign ready     = ready_r;
    assign arb_state = state_r;

endmodule

// File: tb/tb_maria_bus_arbiter.sv
// Scoreboard bench for maria_bus_arbiter. Two instances run side by side
// on the same stimulus: the default build (2/1) and a 1/7 build. A
// behavioural model predicts each clock's outputs; the stimulus process
// pushes predictions and a monitor pops and compares them.
module tb_maria_bus_arbiter;

    localparam int HL_A = 2;
    localparam int RG_A = 1;
    localparam int HL_B = 1;
    localparam int RG_B = 7;

    typedef struct packed {
        logic       halt_b;
        logic       ready;
        logic       drive_ab;
        logic [1:0] st;
    } obs_t;

    logic       sysclock = 1'b0;
    logic       reset    = 1'b1;
    logic       cce      = 1'b0;
    logic       req      = 1'b0;
    logic       done     = 1'b0;
    logic       dr       = 1'b0;
    logic       ls       = 1'b0;
    logic       a_halt_b, a_ready, a_drive;
    logic       b_halt_b, b_ready, b_drive;
    logic [1:0] a_state, b_state;

    obs_t q_a[$];
    obs_t q_b[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model: phase 0..3 as named in the spec, strobes remaining, WSYNC hold.
    int   m_phase [2];
    int   m_left  [2];
    bit   m_hold  [2];

    always #5 sysclock = ~sysclock;

    maria_bus_arbiter #(.HALT_LATENCY(HL_A), .RELEASE_GAP(RG_A)) dut_a (
        .sysclock(sysclock), .reset(reset), .cpu_cycle_end(cce), .dma_req(req),
        .dma_done(done), .deassert_ready(dr), .line_start(ls),
        .halt_b(a_halt_b), .ready(a_ready), .drive_AB(a_drive), .arb_state(a_state)
    );

    maria_bus_arbiter #(.HALT_LATENCY(HL_B), .RELEASE_GAP(RG_B)) dut_b (
        .sysclock(sysclock), .reset(reset), .cpu_cycle_end(cce), .dma_req(req),
        .dma_done(done), .deassert_ready(dr), .line_start(ls),
        .halt_b(b_halt_b), .ready(b_ready), .drive_AB(b_drive), .arb_state(b_state)
    );

    function automatic obs_t model_step(int k, bit rst, bit c, bit rq, bit dn, bit wr, bit lsx);
        obs_t e;
        int hl;
        int rg;
        hl = (k == 0) ? HL_A : HL_B;
        rg = (k == 0) ? RG_A : RG_B;
        if (rst) begin
            m_phase[k] = 0;
            m_left[k]  = 0;
            m_hold[k]  = 1'b0;
        end else begin
            if (wr) m_hold[k] = 1'b1;
            else if (lsx) m_hold[k] = 1'b0;
            case (m_phase[k])
                0: if (c && rq) begin m_phase[k] = 1; m_left[k] = hl; end
                1: if (!rq) begin
                       m_phase[k] = 3; m_left[k] = rg;
                   end else if (c) begin
                       m_left[k] = m_left[k] - 1;
                       if (m_left[k] == 0) m_phase[k] = 2;
                   end
                2: if (dn) begin m_phase[k] = 3; m_left[k] = rg; end
                3: if (c) begin
                       m_left[k] = m_left[k] - 1;
                       if (m_left[k] == 0) m_phase[k] = 0;
                   end
                default: m_phase[k] = 0;
            endcase
        end
        e.halt_b   = (m_phase[k] == 0);
        e.ready    = !m_hold[k];
        e.drive_ab = (m_phase[k] == 2);
        e.st       = 2'(m_phase[k]);
        return e;
    endfunction

    task automatic check(string nm, obs_t got, obs_t exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got halt_b=%b ready=%b drive_AB=%b state=%0d, expected halt_b=%b ready=%b drive_AB=%b state=%0d",
                     nm, cyc, got.halt_b, got.ready, got.drive_ab, got.st,
                     exp.halt_b, exp.ready, exp.drive_ab, exp.st);
        end
    endtask

    // One clock of stimulus: drive on the falling edge, queue predictions.
    task automatic tick(bit rst, bit c, bit rq, bit dn, bit wr, bit lsx);
        @(negedge sysclock);
        reset = rst; cce = c; req = rq; done = dn; dr = wr; ls = lsx;
        q_a.push_back(model_step(0, rst, c, rq, dn, wr, lsx));
        q_b.push_back(model_step(1, rst, c, rq, dn, wr, lsx));
        cyc++;
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic async_reset_check();
        obs_t rv;
        rv = {1'b1, 1'b1, 1'b0, 2'd0};
        @(negedge sysclock);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_a", {a_halt_b, a_ready, a_drive, a_state}, rv);
        check("async_reset_b", {b_halt_b, b_ready, b_drive, b_state}, rv);
        cce = 1'b0; req = 1'b0; done = 1'b0; dr = 1'b0; ls = 1'b0;
        q_a.push_back(model_step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        q_b.push_back(model_step(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc++;
    endtask

    // Monitor: one prediction per DUT per clock, compared after the edge.
    initial begin
        obs_t ea;
        obs_t eb;
        forever begin
            @(posedge sysclock);
            #1;
            if (q_a.size() > 0) begin
                ea = q_a.pop_front();
                check("dut_a", {a_halt_b, a_ready, a_drive, a_state}, ea);
            end
            if (q_b.size() > 0) begin
                eb = q_b.pop_front();
                check("dut_b", {b_halt_b, b_ready, b_drive, b_state}, eb);
            end
        end
    end

    initial begin
        bit rq;
        bit pend_drop;
        bit dn;
        int period;
        int r;
        int n;

        // Reset, then idle with strobes every 4 clocks and spurious dma_done.
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++)
            tick(1'b0, (cyc % 4) == 0, 1'b0, (i == 5) || (i == 13), 1'b0, 1'b0);

        // Full DMA sequence; request raised between strobes.
        n = 0;
        while ((cyc % 4) != 2 && n < 8) begin tick(1'b0, (cyc % 4) == 0, 1'b0, 1'b0, 1'b0, 1'b0); n++; end
        n = 0;
        while (m_phase[0] != 2 && n < 40) begin tick(1'b0, (cyc % 4) == 0, 1'b1, 1'b0, 1'b0, 1'b0); n++; end
        repeat (3) tick(1'b0, (cyc % 4) == 0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, (cyc % 4) == 0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (32) tick(1'b0, (cyc % 4) == 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Request withdrawn during the halt wait.
        n = 0;
        while (m_phase[0] != 1 && n < 20) begin tick(1'b0, (cyc % 4) == 0, 1'b1, 1'b0, 1'b0, 1'b0); n++; end
        repeat (32) tick(1'b0, (cyc % 4) == 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, (cyc % 4) == 0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (32) tick(1'b0, (cyc % 4) == 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // WSYNC hold, release, and simultaneous set/clear.
        tick(1'b0, (cyc % 4) == 0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (12) tick(1'b0, (cyc % 4) == 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, (cyc % 4) == 0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick(1'b0, (cyc % 4) == 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, (cyc % 4) == 0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (6) tick(1'b0, (cyc % 4) == 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, (cyc % 4) == 0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick(1'b0, (cyc % 4) == 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while in DMA with the WSYNC hold set.
        n = 0;
        while (m_phase[0] != 2 && n < 40) begin tick(1'b0, (cyc % 4) == 0, 1'b1, 1'b0, 1'b0, 1'b0); n++; end
        tick(1'b0, (cyc % 4) == 0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (2) tick(1'b0, (cyc % 4) == 0, 1'b1, 1'b0, 1'b0, 1'b0);
        async_reset_check();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) tick(1'b0, (cyc % 4) == 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomised traffic.
        rq = 1'b0;
        pend_drop = 1'b0;
        period = 4;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 500) == 0) period = $urandom_range(2, 6);
            dn = 1'b0;
            if (pend_drop) begin
                rq = 1'b0;
                pend_drop = 1'b0;
            end else if (!rq) begin
                rq = ($urandom_range(0, 7) == 0);
            end else begin
                r = $urandom_range(0, 31);
                if (r < 2) begin dn = 1'b1; pend_drop = 1'b1; end
                else if (r == 2) rq = 1'b0;
            end
            tick($urandom_range(0, 999) == 0, (cyc % period) == 0, rq, dn,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 11) == 0);
        end

        // Drain the scoreboard, bounded.
        repeat (2) @(posedge sysclock);
        #3;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d/%0d pending, expected 0/0", q_a.size(), q_b.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/maria_bus_arbiter.md
# maria_bus_arbiter

Sequences ownership of the system bus between the 6502 and MARIA DMA. It holds the CPU off the bus with `halt_b` on a CPU-cycle boundary and waits a fixed number of CPU cycles before granting MARIA the address bus (`drive_AB`). It returns the bus after DMA completes. Independently, it converts the register file's WSYNC `deassert_ready` pulse into a CPU `ready` hold that lasts until the next line start.

## Interface
Parameters:
- `HALT_LATENCY`, 2: CPU cycles between `halt_b` falling and `drive_AB` rising; legal 1..7.
- `RELEASE_GAP`, 1: CPU cycles between `drive_AB` falling and `halt_b` rising; legal 1..7.

Ports:
- `sysclock`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_cycle_end`  in  1  one-`sysclock` strobe marking the end of each CPU bus cycle.
- `dma_req`  in  1  MARIA DMA request, level; held until `dma_done`.
- `dma_done`  in  1  one-cycle pulse: MARIA finished its DMA burst.
- `deassert_ready`  in  1  one-cycle pulse from the MARIA register file on a WSYNC write.
- `line_start`  in  1  one-cycle pulse at the start of each horizontal line.
- `halt_b`  out  1  CPU halt, active low.
- `ready`  out  1  CPU RDY.
- `drive_AB`  out  1  MARIA owns the address bus (DMA grant).
- `arb_state`  out  2  current FSM state encoding, for debug and status.

## Operation
- Reset values: `halt_b`=1, `ready`=1, `drive_AB`=0, `arb_state`=IDLE, counter=0, `wsync_hold`=0.
- FSM states and transitions:
  - IDLE (0): on `cpu_cycle_end` with `dma_req`=1, drive `halt_b`=0, load counter=`HALT_LATENCY`, go to HALT_WAIT. `dma_req` is not sampled without `cpu_cycle_end`.
  - HALT_WAIT (1): each `cpu_cycle_end` decrements the counter.
    - When the counter reaches 0, drive `drive_AB`=1 and go to DMA.
    - If `dma_req` falls while in this state, go to RELEASE with counter=`RELEASE_GAP`; `drive_AB` is never asserted.
  - DMA (2): on `dma_done`, drive `drive_AB`=0, load counter=`RELEASE_GAP`, go to RELEASE. `cpu_cycle_end` is ignored here.
  - RELEASE (3): each `cpu_cycle_end` decrements the counter. At 0, drive `halt_b`=1 and go to IDLE. A still-high `dma_req` is re-evaluated at the next `cpu_cycle_end` from IDLE, never in the same cycle.
- `dma_done` outside DMA is ignored.
- WSYNC behaviour:
  - `deassert_ready` sets `wsync_hold`; `line_start` clears it; `ready` = ~`wsync_hold`.
  - Simultaneous set and clear: set wins, so the hold lasts until the following `line_start`.
  - The WSYNC logic is independent of the FSM; `ready` can be low during any arbiter state.
- Counter width is 3 bits and never wraps: a decrement at 0 cannot occur because the state exits at 0.

## Timing
- All outputs are registered and change on the `sysclock` edge after the qualifying input is sampled.
- `halt_b` falls 1 cycle after the `cpu_cycle_end` that samples `dma_req`.
- `drive_AB` rises 1 cycle after the `HALT_LATENCY`-th subsequent `cpu_cycle_end`.
- `drive_AB` falls 1 cycle after `dma_done`.
- `halt_b` rises 1 cycle after the `RELEASE_GAP`-th `cpu_cycle_end` following `dma_done`.
- `drive_AB`=1 implies `halt_b`=0 in every cycle; the two are never both released or both asserted-with-bus-free.
- `ready` falls 1 cycle after `deassert_ready` and rises 1 cycle after `line_start`.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronous). After reset deasserts, the FSM waits in IDLE for a fresh `cpu_cycle_end`.

## Structure
- The state typedef `arb_state_t` (IDLE=0, HALT_WAIT=1, DMA=2, RELEASE=3) and the parameter defaults go in the shared `atari7800.vh` header alongside the chip-select macros.
- One sub-module is natural: `cpu_cycle_counter` (load, decrement on strobe, zero flag, 3-bit). The WSYNC latch and FSM stay in the top module.

## Test plan
- Reset then idle with `cpu_cycle_end` every 4 clocks -> `halt_b`=1, `ready`=1, `drive_AB`=0, `arb_state`=0 throughout.
- `dma_req`=1 at cycle 10 (between strobes), next strobe at cycle 12 -> `halt_b`=0 at 13; with defaults, `drive_AB`=1 one clock after the 2nd later strobe. Pulse `dma_done` -> `drive_AB`=0 next clock; `halt_b`=1 one clock after the following strobe; `arb_state` traces 0,1,2,3,0.
- `dma_req` dropped in HALT_WAIT -> `drive_AB` stays 0; after `RELEASE_GAP` strobes, `halt_b`=1 and state=IDLE.
- `deassert_ready` pulse -> `ready`=0 next clock and held across 3 `cpu_cycle_end`; `line_start` -> `ready`=1 next clock. Both pulsed in the same cycle -> `ready` stays 0 until a second `line_start`.
- `reset` asserted while `arb_state`=2 with `wsync_hold` set -> `drive_AB`=0, `halt_b`=1, `ready`=1 asynchronously, before the next clock edge.
- Spurious `dma_done` in IDLE, and `HALT_LATENCY`=1 / `RELEASE_GAP`=7 build -> spurious pulse has no effect; latency counts match the parameters exactly.
